dff_pipe: RTL and testbench

- Parametrised successor to the plain D flip-flop: a DEPTH-stage, WIDTH-bit register pipeline with per-stage valid bits.
- Adds valid/ready flow control with bubble collapsing, asynchronous reset to a programmable value, synchronous flush and an occupancy count.
- Generic library block for retiming long datapaths between producer/consumer blocks that use a valid/ready handshake.

---
 rtl/dff_pipe.sv | 84 ++++++++
 tb/tb_dff_pipe.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dff_pipe.sv
// DEPTH-stage valid/ready register pipeline. Empty stages absorb data while downstream is stalled.
// Also provides flush, asynchronous reset to RESET_VALUE and a registered occupancy count.
module dff_pipe #(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH+1);

    if (DEPTH < 1) begin : g_depth_check
        $error("dff_pipe: DEPTH must be >= 1");
    end

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] rdy;
    logic             in_acc;
    logic             out_acc;

    // A stage may advance when it or any stage downstream of it is empty, or the sink takes data.
    // Each bit is formed directly from vld_q so the chain has no self-referencing vector.
    always_comb begin
        logic r;
        rdy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            r = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                r = r | ~vld_q[j];
            end
            rdy[i] = r;
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign in_acc    = in_valid & in_ready;
    assign out_acc   = vld_q[DEPTH-1] & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VALUE;
            end
        end else if (flush) begin
            // Data flops keep their contents; only occupancy is cleared.
            vld_q <= '0;
            count <= '0;
        end else begin
            if (rdy[0]) begin
                vld_q[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= in_data;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    vld_q[i] <= vld_q[i-1];
                    if (vld_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
            case ({in_acc, out_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe with WIDTH=8, DEPTH=3 and RESET_VALUE=8'hA5.
// Stimulus pushes expected outputs to a queue, and a negedge monitor pops that queue on every delivered output.
module tb_dff_pipe;
    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam logic [7:0] RV = 8'hA5;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       flush;
    logic [1:0] count;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE(RV)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .flush(flush), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until every expected item has been delivered, then let the final transfer complete.
    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk({name, "_drain_left"}, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out got %0h expected none at %0t", out_data, $time);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; flush = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, RV);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        step(); step();
        rst = 1'b0;
        step();

        // streaming
        out_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            chk("stream_in_ready", in_ready, 1);
            exp_q.push_back(8'(k));
            step();
            if (k < 3) begin
                chk("stream_lat_valid", out_valid, 0);
            end else begin
                chk("stream_valid", out_valid, 1);
                chk("stream_count", count, 3);
            end
        end
        in_valid = 1'b0;
        drain("stream");
        chk("stream_end_count", count, 0);
        chk("stream_end_valid", out_valid, 0);

        // fill and stall
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 8'h11; exp_q.push_back(8'h11); step();
        in_data = 8'h22; exp_q.push_back(8'h22); step();
        in_data = 8'h33; exp_q.push_back(8'h33); step();
        in_data = 8'h44; exp_q.push_back(8'h44);
        chk("fill_count", count, 3);
        chk("fill_in_ready", in_ready, 0);
        step(); step();
        chk("stall_count", count, 3);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_data", out_data, 8'h11);
        chk("stall_out_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        chk("full_release_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("swap_count", count, 3);
        chk("swap_out_data", out_data, 8'h22);
        drain("fill");
        chk("fill_end_count", count, 0);

        // bubble collapse
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h55; exp_q.push_back(8'h55); step();
        in_valid = 1'b0; step();
        in_valid = 1'b1; in_data = 8'h66; exp_q.push_back(8'h66); step();
        in_valid = 1'b0; step();
        chk("bubble_count", count, 2);
        chk("bubble_in_ready", in_ready, 1);
        chk("bubble_out_data", out_data, 8'h55);
        chk("bubble_stage1", dut.data_q[1], 8'h66);
        step();
        chk("bubble_hold_count", count, 2);

        // flush with a full pipe
        in_valid = 1'b1; in_data = 8'h77; exp_q.push_back(8'h77); step();
        in_valid = 1'b0;
        chk("preflush_count", count, 3);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        chk("flush_out_valid_same_cycle", out_valid, 1);
        step();
        flush = 1'b0;
        exp_q.delete();
        chk("flush_out_valid", out_valid, 0);
        chk("flush_count", count, 0);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'hC3; exp_q.push_back(8'hC3); step();
        in_valid = 1'b0;
        chk("postflush_lat1", out_valid, 0);
        step();
        chk("postflush_lat2", out_valid, 0);
        step();
        chk("postflush_valid", out_valid, 1);
        chk("postflush_data", out_data, 8'hC3);
        step();
        chk("postflush_count", count, 0);

        // flush gates in_ready even when the pipe could accept
        flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        #1;
        chk("flush_empty_in_ready", in_ready, 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_empty_count", count, 0);
        repeat (5) step();
        chk("flush_empty_no_out", out_valid, 0);

        // async reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h12; exp_q.push_back(8'h12); step();
        in_data = 8'h34; exp_q.push_back(8'h34); step();
        in_valid = 1'b0;
        chk("prereset_count", count, 2);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, RV);
        chk("midrst_count", count, 0);
        exp_q.delete();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        chk("postrst_out_valid", out_valid, 0);
        chk("postrst_count", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
